// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core. It walks each instruction
// through fetch, decode, execute, memory and write-back, and traps on an illegal opcode or a bus timeout.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state,
    output logic [31:0] retire_count
);

    // Handshake: imem_req/dmem_req stay high until the matching ready is seen;
    // a transfer completes in the cycle where req and ready are both high.

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_IMM    = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8,
        CL_NONE   = 4'd9
    } op_class_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_LOAD  = 2'b01;
    localparam logic [1:0] WB_LINK  = 2'b10;
    localparam logic [1:0] WB_IMM   = 2'b11;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic TIMEOUT_ON = (MEM_TIMEOUT != 0);

    state_t            state_q, state_d;
    op_class_t         class_q, class_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       retire_q, retire_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic              retire_inc;
    logic              mem_wait;
    logic              sel_a_pc;
    logic              sel_b_imm;

    function automatic op_class_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return CL_R;
            7'b0010011: return CL_IMM;
            7'b0000011: return CL_LOAD;
            7'b0100011: return CL_STORE;
            7'b1100011: return CL_BRANCH;
            7'b1101111: return CL_JAL;
            7'b1100111: return CL_JALR;
            7'b0110111: return CL_LUI;
            7'b0010111: return CL_AUIPC;
            default:    return CL_NONE;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            class_q   <= CL_NONE;
            wait_q    <= '0;
            retire_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retire_inc = 1'b0;
        mem_wait   = 1'b0;

        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        alu_a_pc   = 1'b0;
        alu_b_imm  = 1'b0;

        sel_a_pc  = (class_q == CL_AUIPC) || (class_q == CL_BRANCH) || (class_q == CL_JAL);
        sel_b_imm = (class_q == CL_IMM) || (class_q == CL_LOAD) ||
                    (class_q == CL_STORE) || (class_q == CL_JALR);

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end

            ST_DECODE: begin
                class_d = classify(opcode);
                if (class_d == CL_NONE) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                alu_a_pc  = sel_a_pc;
                alu_b_imm = sel_b_imm;
                case (class_q)
                    CL_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
                        retire_inc = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                // Operand selects stay up so the address is stable for the whole access.
                alu_a_pc  = sel_a_pc;
                alu_b_imm = sel_b_imm;
                dmem_req  = 1'b1;
                dmem_we   = (class_q == CL_STORE);
                if (dmem_ready) begin
                    if (class_q == CL_STORE) begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_PLUS4;
                        retire_inc = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    mem_wait = 1'b1;
                end
            end

            ST_WB: begin
                alu_a_pc   = sel_a_pc;
                alu_b_imm  = sel_b_imm;
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                retire_inc = 1'b1;
                state_d    = ST_FETCH;
                case (class_q)
                    CL_LOAD: wb_sel = WB_LOAD;
                    CL_JAL: begin
                        wb_sel = WB_LINK;
                        pc_sel = PC_IMM;
                    end
                    CL_JALR: begin
                        wb_sel = WB_LINK;
                        pc_sel = PC_JALR;
                    end
                    CL_LUI:  wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase

        // The limit is compared against the registered count, so a ready that
        // arrives in the limit cycle still completes the transfer.
        if (mem_wait && TIMEOUT_ON && (wait_q == WAIT_LIMIT)) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_wait) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        retire_d = retire_inc ? (retire_q + 32'd1) : retire_q;
    end

    assign state        = state_q;
    assign retire_count = retire_q;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// corner sequences and randomized instructions checked against a latency model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_req;
    logic        imem_ready;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic        illegal;
    logic        bus_err;
    logic [2:0]  state;
    logic [31:0] retire_count;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_pc     (alu_a_pc),
        .alu_b_imm    (alu_b_imm),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state),
        .retire_count (retire_count)
    );

    wire [11:0] strobes = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
                           rf_we, wb_sel, alu_a_pc, alu_b_imm};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- observation / expectation records ----------------
    typedef struct {
        int cycles;
        int imem_n;
        int ir_we_n;
        int dmem_n;
        int dmem_we_n;
        int pc_we_n;
        int rf_we_n;
        int pc_sel;
        int wb_sel;
        int a_pc;
        int b_imm;
        int end_state;
        int illegal;
        int bus_err;
        int retire;
        int bound_hit;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         iw;
        int         dw;
        int         cycles;
        int         pc_sel;
        int         wb_sel;
        int         rf;
        int         dmem_n;
        int         end_state;
        int         flags;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; memory readies are raised after
    // iw / dw wait cycles. Stops on the return to FETCH or on TRAP.
    task automatic run_instr(input logic [6:0] op, input logic bt, input int iw,
                             input int dw, output obs_t o);
        int          fn;
        int          mn;
        bit          left_fetch;
        bit          done;
        logic [31:0] r0;
        o          = '{default: 0};
        fn         = 0;
        mn         = 0;
        left_fetch = 1'b0;
        done       = 1'b0;
        r0         = retire_count;
        opcode       = op;
        branch_taken = bt;
        for (int c = 0; c < 64 && !done; c++) begin
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (state == 3'd1) begin
                imem_ready = (fn == iw);
                fn++;
            end
            if (state == 3'd4) begin
                dmem_ready = (mn == dw);
                mn++;
            end
            @(negedge clk);
            o.cycles++;
            o.imem_n    += int'(imem_req);
            o.ir_we_n   += int'(ir_we);
            o.dmem_n    += int'(dmem_req);
            o.dmem_we_n += int'(dmem_we);
            if (pc_we) begin
                o.pc_we_n++;
                o.pc_sel = int'(pc_sel);
            end
            if (rf_we) begin
                o.rf_we_n++;
                o.wb_sel = int'(wb_sel);
            end
            if (state == 3'd3) begin
                o.a_pc  = int'(alu_a_pc);
                o.b_imm = int'(alu_b_imm);
            end
            if (state != 3'd1) left_fetch = 1'b1;
            @(posedge clk);
            #1;
            if (state == 3'd6 || (state == 3'd1 && left_fetch)) done = 1'b1;
        end
        o.bound_hit = done ? 0 : 1;
        o.end_state = int'(state);
        o.illegal   = int'(illegal);
        o.bus_err   = int'(bus_err);
        o.retire    = int'(retire_count - r0);
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Instruction-level latency/strobe model: 0 R, 1 I, 2 LD, 3 ST, 4 BR,
    // 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, -1 unsupported.
    function automatic int op_kind(input logic [6:0] op);
        case (op)
            7'h33: return 0;
            7'h13: return 1;
            7'h03: return 2;
            7'h23: return 3;
            7'h63: return 4;
            7'h6F: return 5;
            7'h67: return 6;
            7'h37: return 7;
            7'h17: return 8;
            default: return -1;
        endcase
    endfunction

    function automatic obs_t model(input logic [6:0] op, input logic bt, input int iw, input int dw);
        obs_t e;
        int   k;
        bit   ldst;
        e = '{default: 0};
        k = op_kind(op);
        if (iw > TO) begin
            e.cycles    = TO + 1;
            e.imem_n    = TO + 1;
            e.end_state = 6;
            e.bus_err   = 1;
            return e;
        end
        e.imem_n  = iw + 1;
        e.ir_we_n = 1;
        if (k < 0) begin
            e.cycles    = iw + 2;
            e.end_state = 6;
            e.illegal   = 1;
            return e;
        end
        e.a_pc  = (k == 8 || k == 4 || k == 5) ? 1 : 0;
        e.b_imm = (k == 1 || k == 2 || k == 3 || k == 6) ? 1 : 0;
        ldst = (k == 2 || k == 3);
        if (ldst && dw > TO) begin
            e.cycles    = iw + 3 + TO + 1;
            e.dmem_n    = TO + 1;
            e.dmem_we_n = (k == 3) ? TO + 1 : 0;
            e.end_state = 6;
            e.bus_err   = 1;
            return e;
        end
        e.end_state = 1;
        e.retire    = 1;
        e.pc_we_n   = 1;
        if (ldst) begin
            e.dmem_n    = dw + 1;
            e.dmem_we_n = (k == 3) ? dw + 1 : 0;
        end
        if (k == 4) begin
            e.cycles = iw + 3;
            e.pc_sel = bt ? 1 : 0;
        end else if (k == 3) begin
            e.cycles = iw + 4 + dw;
        end else begin
            e.cycles  = iw + 4 + ((k == 2) ? dw + 1 : 0);
            e.rf_we_n = 1;
            e.wb_sel  = (k == 2) ? 1 : (k == 5 || k == 6) ? 2 : (k == 7) ? 3 : 0;
            e.pc_sel  = (k == 5) ? 1 : (k == 6) ? 2 : 0;
        end
        return e;
    endfunction

    task automatic compare_obs(input int n, input obs_t o, input obs_t e);
        check($sformatf("rnd%0d_cycles", n),  o.cycles,    e.cycles);
        check($sformatf("rnd%0d_imem", n),    o.imem_n,    e.imem_n);
        check($sformatf("rnd%0d_ir_we", n),   o.ir_we_n,   e.ir_we_n);
        check($sformatf("rnd%0d_dmem", n),    o.dmem_n,    e.dmem_n);
        check($sformatf("rnd%0d_dmem_we", n), o.dmem_we_n, e.dmem_we_n);
        check($sformatf("rnd%0d_pc_we", n),   o.pc_we_n,   e.pc_we_n);
        check($sformatf("rnd%0d_rf_we", n),   o.rf_we_n,   e.rf_we_n);
        check($sformatf("rnd%0d_pc_sel", n),  o.pc_sel,    e.pc_sel);
        check($sformatf("rnd%0d_wb_sel", n),  o.wb_sel,    e.wb_sel);
        check($sformatf("rnd%0d_a_pc", n),    o.a_pc,      e.a_pc);
        check($sformatf("rnd%0d_b_imm", n),   o.b_imm,     e.b_imm);
        check($sformatf("rnd%0d_state", n),   o.end_state, e.end_state);
        check($sformatf("rnd%0d_illegal", n), o.illegal,   e.illegal);
        check($sformatf("rnd%0d_bus_err", n), o.bus_err,   e.bus_err);
        check($sformatf("rnd%0d_retire", n),  o.retire,    e.retire);
        check($sformatf("rnd%0d_bound", n),   o.bound_hit, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t       vecs[15];
        obs_t       o;
        obs_t       e;
        logic [2:0] trace[4];
        logic [6:0] ops[9];
        logic [5:0] wb_flags;
        int         hold_bad;
        bit         reached;

        // op, bt, iw, dw | cycles, pc_sel, wb_sel, rf, dmem_n, end_state, {illegal,bus_err}
        vecs[0]  = '{7'h33, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1, 0};
        vecs[1]  = '{7'h13, 1'b0, 1, 0, 5, 0, 0, 1, 0, 1, 0};
        vecs[2]  = '{7'h03, 1'b0, 0, 3, 8, 0, 1, 1, 4, 1, 0};
        vecs[3]  = '{7'h23, 1'b0, 0, 0, 4, 0, 0, 0, 1, 1, 0};
        vecs[4]  = '{7'h63, 1'b1, 0, 0, 3, 1, 0, 0, 0, 1, 0};
        vecs[5]  = '{7'h63, 1'b0, 0, 0, 3, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{7'h6F, 1'b0, 0, 0, 4, 1, 2, 1, 0, 1, 0};
        vecs[7]  = '{7'h67, 1'b0, 0, 0, 4, 2, 2, 1, 0, 1, 0};
        vecs[8]  = '{7'h37, 1'b0, 0, 0, 4, 0, 3, 1, 0, 1, 0};
        vecs[9]  = '{7'h17, 1'b0, 2, 0, 6, 0, 0, 1, 0, 1, 0};
        vecs[10] = '{7'h23, 1'b0, 0, 4, 8, 0, 0, 0, 5, 1, 0};
        vecs[11] = '{7'h03, 1'b0, 0, 5, 8, 0, 0, 0, 5, 6, 1};
        vecs[12] = '{7'h7F, 1'b0, 0, 0, 2, 0, 0, 0, 0, 6, 2};
        vecs[13] = '{7'h33, 1'b0, 4, 0, 8, 0, 0, 1, 0, 1, 0};
        vecs[14] = '{7'h33, 1'b0, 5, 0, 5, 0, 0, 0, 0, 6, 1};

        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        rst_n        = 1'b0;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b0;

        // Reset held with imem_ready high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",   state, 3'd0);
        check("reset_strobes", strobes, 12'd0);
        check("reset_retire",  retire_count, 32'd0);
        check("reset_flags",   {illegal, bus_err}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_state", state, 3'd1);
        check("release_imem",  imem_req, 1'b1);

        // R-type with zero-wait fetch: states 1,2,3,5 then retire
        opcode     = 7'h33;
        imem_ready = 1'b1;
        wb_flags   = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            trace[i] = state;
            if (i == 3) wb_flags = {rf_we, pc_we, wb_sel, pc_sel};
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        check("radd_trace0", trace[0], 3'd1);
        check("radd_trace1", trace[1], 3'd2);
        check("radd_trace2", trace[2], 3'd3);
        check("radd_trace3", trace[3], 3'd5);
        check("radd_wb",     wb_flags, 6'b11_00_00);
        check("radd_retire", retire_count, 32'd1);
        check("radd_fetch",  state, 3'd1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].op, vecs[i].bt, vecs[i].iw, vecs[i].dw, o);
            check($sformatf("vec%0d_cycles", i), o.cycles,    vecs[i].cycles);
            check($sformatf("vec%0d_pc_sel", i), o.pc_sel,    vecs[i].pc_sel);
            check($sformatf("vec%0d_wb_sel", i), o.wb_sel,    vecs[i].wb_sel);
            check($sformatf("vec%0d_rf_we", i),  o.rf_we_n,   vecs[i].rf);
            check($sformatf("vec%0d_dmem", i),   o.dmem_n,    vecs[i].dmem_n);
            check($sformatf("vec%0d_state", i),  o.end_state, vecs[i].end_state);
            check($sformatf("vec%0d_flags", i),  o.illegal * 2 + o.bus_err, vecs[i].flags);
            check($sformatf("vec%0d_retire", i), o.retire, (vecs[i].end_state == 1) ? 1 : 0);
            if (o.end_state != 1) do_reset();
        end

        // Illegal opcode: TRAP is held with illegal set and every strobe low
        run_instr(7'h7F, 1'b0, 0, 0, o);
        check("ill_state", o.end_state, 6);
        hold_bad = 0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state != 3'd6 || illegal != 1'b1 || strobes != 12'd0) hold_bad++;
            @(posedge clk);
            #1;
        end
        check("ill_hold", hold_bad, 0);
        do_reset();

        // Reset asserted while a load sits in MEM aborts it
        opcode     = 7'h03;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        reached    = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(posedge clk);
            #1;
            if (state == 3'd4) reached = 1'b1;
        end
        check("abort_reach_mem", reached, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_state",   state, 3'd0);
        check("abort_strobes", strobes, 12'd0);
        check("abort_retire",  retire_count, 32'd0);
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized instructions against the model
        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            logic       bt;
            int         iw;
            int         dw;
            int         r;
            r  = $urandom_range(0, 19);
            op = (r < 18) ? ops[r % 9] : 7'($urandom_range(0, 127));
            bt = 1'($urandom_range(0, 1));
            iw = ($urandom_range(0, 14) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            dw = ($urandom_range(0, 7) == 0)  ? $urandom_range(3, 6) : $urandom_range(0, 2);
            e  = model(op, bt, iw, dw);
            run_instr(op, bt, iw, dw, o);
            compare_obs(n, o, e);
            if (o.end_state != 1) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
